// File: rtl/ram_wb_pkg.sv
// Shared types and constants for the Wishbone front end of the 6Kx32 RAM.
package ram_wb_pkg;

    // Word-address width of the RAM macro (8K word address space, 6K populated).
    localparam int RAM_AW = 13;

    // Default number of implemented 32-bit words.
    localparam int unsigned WORDS_DEFAULT = 6144;

    // Byte span of the decoded window: one word address space of RAM_AW bits.
    localparam int WIN_LSB = RAM_AW + 2;

    // Bus-cycle sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    // Byte-lane write strobes actually sent to the RAM: reads never strobe.
    function automatic logic [3:0] lane_strobes(input logic we, input logic [3:0] sel);
        return we ? sel : 4'h0;
    endfunction

endpackage

// File: rtl/ram_wb_addr_dec.sv
// Combinational address decode: window match and in-range word index.
module ram_wb_addr_dec
    import ram_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned WORDS     = WORDS_DEFAULT
) (
    input  logic [31:0]       i_adr,
    output logic              o_hit,
    output logic [RAM_AW-1:0] o_idx
);

    logic        w_win_match;
    logic        w_in_range;
    logic        w_unused_lsb;

    // Byte offset inside a word carries no meaning for a 32-bit RAM.
    assign w_unused_lsb = ^i_adr[1:0];

    assign o_idx       = i_adr[WIN_LSB-1:2];
    assign w_win_match = (i_adr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
    // The window spans 8K words but only WORDS of them exist.
    assign w_in_range  = ({{(32-RAM_AW){1'b0}}, o_idx} < 32'(WORDS));
    assign o_hit       = w_win_match && w_in_range;

endmodule

// File: rtl/ram_6kx32_wb_port.sv
// Wishbone-classic slave in front of the 6Kx32 DFFRAM: one enable pulse per
// access, registered RAM-side signals, registered single-cycle ack/err.
module ram_6kx32_wb_port
    import ram_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned WORDS     = WORDS_DEFAULT
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_a,
    output logic [31:0]       ram_di,
    input  logic [31:0]       ram_do
);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_wr_op;
    logic                w_wr_op_next;
    logic                r_ram_en;
    logic                w_ram_en_next;
    logic [3:0]          r_ram_we;
    logic [3:0]          w_ram_we_next;
    logic [RAM_AW-1:0]   r_ram_a;
    logic [RAM_AW-1:0]   w_ram_a_next;
    logic [31:0]         r_ram_di;
    logic [31:0]         w_ram_di_next;
    logic [31:0]         r_dat_o;
    logic [31:0]         w_dat_o_next;
    logic                r_ack;
    logic                w_ack_next;
    logic                r_err;
    logic                w_err_next;

    logic                w_req;
    logic                w_hit;
    logic [RAM_AW-1:0]   w_idx;

    assign w_req = wb_cyc_i && wb_stb_i;

    ram_wb_addr_dec #(
        .BASE_ADDR (BASE_ADDR),
        .WORDS     (WORDS)
    ) u_dec (
        .i_adr (wb_adr_i),
        .o_hit (w_hit),
        .o_idx (w_idx)
    );

    // Next-state and next-output decode; enable/strobes and ack/err default
    // low so each is a single-cycle pulse, address/data/read value hold.
    always_comb begin
        w_state_next  = r_state;
        w_wr_op_next  = r_wr_op;
        w_ram_en_next = 1'b0;
        w_ram_we_next = 4'h0;
        w_ram_a_next  = r_ram_a;
        w_ram_di_next = r_ram_di;
        w_dat_o_next  = r_dat_o;
        w_ack_next    = 1'b0;
        w_err_next    = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        w_ram_en_next = 1'b1;
                        w_ram_we_next = lane_strobes(wb_we_i, wb_sel_i);
                        w_ram_a_next  = w_idx;
                        w_ram_di_next = wb_dat_i;
                        w_wr_op_next  = wb_we_i;
                        w_state_next  = ACCESS;
                    end else begin
                        w_err_next    = 1'b1;
                        w_state_next  = RESP;
                    end
                end
            end
            ACCESS: begin
                // The RAM commits at the closing edge of this cycle whether
                // or not the master is still there; only the reply is dropped.
                if (!wb_cyc_i) begin
                    w_state_next = IDLE;
                end else if (r_wr_op) begin
                    w_ack_next   = 1'b1;
                    w_state_next = RESP;
                end else begin
                    w_state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!wb_cyc_i) begin
                    w_state_next = IDLE;
                end else begin
                    w_dat_o_next = ram_do;
                    w_ack_next   = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state  <= IDLE;
            r_wr_op  <= 1'b0;
            r_ram_en <= 1'b0;
            r_ram_we <= 4'h0;
            r_ram_a  <= '0;
            r_ram_di <= '0;
            r_dat_o  <= '0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_wr_op  <= w_wr_op_next;
            r_ram_en <= w_ram_en_next;
            r_ram_we <= w_ram_we_next;
            r_ram_a  <= w_ram_a_next;
            r_ram_di <= w_ram_di_next;
            r_dat_o  <= w_dat_o_next;
            r_ack    <= w_ack_next;
            r_err    <= w_err_next;
        end
    end

    assign ram_en   = r_ram_en;
    assign ram_we   = r_ram_we;
    assign ram_a    = r_ram_a;
    assign ram_di   = r_ram_di;
    assign wb_dat_o = r_dat_o;
    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;

endmodule

// File: tb/tb_ram_6kx32_wb_port.sv
// Scoreboard bench for ram_6kx32_wb_port with a behavioural DFFRAM model.
module tb_ram_6kx32_wb_port;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk;
    logic        rst_n;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic        wb_err;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [12:0] ram_a;
    logic [31:0] ram_di;
    logic [31:0] ram_do;

    int total = 0;
    int bad   = 0;
    int cycle_no = 0;
    bit mon_en = 0;
    logic prev_en = 1'b0;

    typedef struct {
        bit          is_err;
        bit          chk_data;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [12:0] a;
        logic [3:0]  we;
        logic [31:0] di;
        int          cyc;
    } ramx_t;

    resp_t resp_q[$];
    ramx_t ram_q[$];

    logic [31:0] mem [0:8191];

    ram_6kx32_wb_port #(.BASE_ADDR(BASE), .WORDS(6144)) dut (
        .CLK      (clk),
        .RSTn     (rst_n),
        .wb_cyc_i (wb_cyc),
        .wb_stb_i (wb_stb),
        .wb_we_i  (wb_we),
        .wb_sel_i (wb_sel),
        .wb_adr_i (wb_adr),
        .wb_dat_i (wb_dat_w),
        .wb_dat_o (wb_dat_r),
        .wb_ack_o (wb_ack),
        .wb_err_o (wb_err),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_a    (ram_a),
        .ram_di   (ram_di),
        .ram_do   (ram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_no <= cycle_no + 1;

    // DFFRAM model: read-before-write, data out the cycle after the enable edge.
    always @(posedge clk) begin
        logic [31:0] w;
        if (ram_en === 1'b1) begin
            w = mem[ram_a];
            ram_do <= w;
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) w[8*b +: 8] = ram_di[8*b +: 8];
            mem[ram_a] <= w;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle_no);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a reply or RAM pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            check("ack_err_exclusive", {31'd0, wb_ack && wb_err}, 32'd0);
            if (ram_en) check("ram_en_single_cycle", {31'd0, prev_en}, 32'd0);
            if (wb_ack || wb_err) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_reply", {30'd0, wb_ack, wb_err}, 32'd0);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    check("reply_kind_err", {31'd0, wb_err}, {31'd0, r.is_err});
                    check("reply_cycle", cycle_no, r.cyc);
                    if (r.chk_data) check("reply_data", wb_dat_r, r.data);
                end
            end
            if (ram_en) begin
                if (ram_q.size() == 0) begin
                    check("unexpected_ram_en", {31'd0, ram_en}, 32'd0);
                end else begin
                    ramx_t x;
                    x = ram_q.pop_front();
                    check("ram_a", {19'd0, ram_a}, {19'd0, x.a});
                    check("ram_we", {28'd0, ram_we}, {28'd0, x.we});
                    if (x.we != 4'h0) check("ram_di", ram_di, x.di);
                    check("ram_cycle", cycle_no, x.cyc);
                end
            end
        end
        prev_en = ram_en;
    end

    // kind: 0 read, 1 write, 2 expected error. chk: compare wb_dat_o on reply.
    task automatic issue(input int kind, input logic we, input logic [31:0] off,
                         input logic [3:0] sel, input logic [31:0] dat,
                         input bit chk, input logic [31:0] exp);
        int k;
        bit got;
        @(negedge clk);
        k = cycle_no + 1;
        resp_q.push_back('{is_err: (kind == 2), chk_data: chk, data: exp,
                           cyc: (kind == 2) ? k : (kind == 1) ? k + 1 : k + 2});
        if (kind != 2)
            ram_q.push_back('{a: off[14:2], we: we ? sel : 4'h0, di: dat, cyc: k});
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_sel = sel;
        wb_adr = BASE + off; wb_dat_w = dat;
        got = 0;
        for (int n = 0; n < 12 && !got; n++) begin
            @(negedge clk);
            if (wb_ack || wb_err) got = 1;
        end
        if (!got) check("reply_timeout", 32'd0, 32'd1);
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ack"}, {31'd0, wb_ack}, 32'd0);
        check({tag, "_err"}, {31'd0, wb_err}, 32'd0);
        check({tag, "_en"}, {31'd0, ram_en}, 32'd0);
        check({tag, "_we"}, {28'd0, ram_we}, 32'd0);
        check({tag, "_a"}, {19'd0, ram_a}, 32'd0);
        check({tag, "_di"}, ram_di, 32'd0);
        check({tag, "_dat"}, wb_dat_r, 32'd0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_sel = 4'h0; wb_adr = '0; wb_dat_w = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        mon_en = 1;

        issue(1, 1'b1, 32'h0000, 4'hF, 32'hDEADBEEF, 0, 32'h0);
        issue(0, 1'b0, 32'h0000, 4'hF, 32'h0,       1, 32'hDEADBEEF);
        issue(1, 1'b1, 32'h0000, 4'b0010, 32'h0000_5A00, 0, 32'h0);
        issue(0, 1'b0, 32'h0000, 4'hF, 32'h0,       1, 32'hDEAD5AEF);
        issue(1, 1'b1, 32'h5FFC, 4'hF, 32'h13579BDF, 0, 32'h0);
        issue(0, 1'b0, 32'h5FFC, 4'hF, 32'h0,       1, 32'h13579BDF);
        // Misses: read data register must keep the last captured value.
        issue(2, 1'b1, 32'h6000, 4'hF, 32'h11111111, 1, 32'h13579BDF);
        issue(2, 1'b0, 32'h8000, 4'hF, 32'h0,       1, 32'h13579BDF);
        issue(2, 1'b0, 32'hF000_0000, 4'hF, 32'h0,  1, 32'h13579BDF);
        issue(1, 1'b1, 32'h0FFC, 4'hF, 32'hA5A51023, 0, 32'h0);
        issue(1, 1'b1, 32'h1000, 4'hF, 32'h5A5A1024, 0, 32'h0);
        issue(0, 1'b0, 32'h0FFC, 4'hF, 32'h0,       1, 32'hA5A51023);
        issue(0, 1'b0, 32'h1000, 4'hF, 32'h0,       1, 32'h5A5A1024);
        issue(1, 1'b1, 32'h0000, 4'h0, 32'hFFFFFFFF, 0, 32'h0);
        issue(0, 1'b0, 32'h0000, 4'hF, 32'h0,       1, 32'hDEAD5AEF);

        // Abort: drop the cycle while the read is in CAPTURE.
        @(negedge clk);
        k = cycle_no + 1;
        ram_q.push_back('{a: 13'd0, we: 4'h0, di: 32'h0, cyc: k});
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF;
        wb_adr = BASE; wb_dat_w = '0;
        @(negedge clk);
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        issue(0, 1'b0, 32'h0FFC, 4'hF, 32'h0, 1, 32'hA5A51023);

        // Reset asserted during a read ACCESS cycle.
        @(negedge clk);
        k = cycle_no + 1;
        ram_q.push_back('{a: 13'h17FF, we: 4'h0, di: 32'h0, cyc: k});
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF;
        wb_adr = BASE + 32'h5FFC;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        check_outputs_zero("midop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("no_ack_after_reset", {31'd0, wb_ack}, 32'd0);
        issue(0, 1'b0, 32'h1000, 4'hF, 32'h0, 1, 32'h5A5A1024);

        repeat (5) @(negedge clk);
        check("resp_q_drained", resp_q.size(), 32'd0);
        check("ram_q_drained", ram_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_6kx32_wb_port.md
# ram_6kx32_wb_port

Wishbone-classic slave port that sits directly upstream of the 6K×32 DFFRAM macro (six 1K×32 banks behind a 13-bit word address). It converts single Wishbone read and write cycles from the SoC interconnect into one-cycle RAM enable pulses with byte write strobes. It registers all RAM-side inputs, captures read data, and returns a registered single-cycle acknowledge. Accesses outside the 24 KB window return an error and never touch the RAM.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000: byte base of the RAM window; must be 32 KB aligned.
- WORDS, 6144: number of 32-bit words implemented; valid word indices are 0..WORDS-1.

Ports:
- CLK  in  1  the single clock; all registers update on its rising edge.
- RSTn  in  1  reset, synchronous and active-low.
- wb_cyc_i  in  1  bus cycle active.
- wb_stb_i  in  1  strobe; a request is present when it and wb_cyc_i are both high.
- wb_we_i  in  1  1 selects write, 0 selects read.
- wb_sel_i  in  4  byte lane selects.
- wb_adr_i  in  32  byte address; bits [1:0] are ignored.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; valid while wb_ack_o is high.
- wb_ack_o  out  1  one-cycle successful completion.
- wb_err_o  out  1  one-cycle error completion.
- ram_en  out  1  RAM EN.
- ram_we  out  4  RAM WE byte strobes.
- ram_a  out  13  RAM word address.
- ram_di  out  32  RAM write data.
- ram_do  in  32  RAM read data; valid the cycle after the edge that samples ram_en high.

## Operation
- Decode:
  - hit = (wb_adr_i[31:15] == BASE_ADDR[31:15]) and (wb_adr_i[14:2] < WORDS).
  - Word index = wb_adr_i[14:2].
- FSM states and transitions:
  - IDLE:
    - Request with hit: load ram_a, ram_di = wb_dat_i, ram_we = (wb_we_i ? wb_sel_i : 0), ram_en = 1, then go to ACCESS.
    - Request with miss: set err, go to RESP.
    - No request: stay in IDLE.
  - ACCESS: ram_en high for exactly this cycle; the RAM operation occurs at this cycle's closing edge.
    - Write: go to RESP with ack.
    - Read: go to CAPTURE.
    - On exit, ram_en and ram_we are cleared.
  - CAPTURE: wb_dat_o <= ram_do, ack set, go to RESP.
  - RESP: wb_ack_o or wb_err_o high for one cycle, then go to IDLE unconditionally.
- wb_dat_o holds the last read value until the next read capture. It is not cleared on writes or errors.
- Write with wb_sel_i = 0: the RAM is still enabled with ram_we = 0 and the cycle is acked. The RAM contents are unchanged.
- Abort: if wb_cyc_i is low in ACCESS or CAPTURE, the RAM operation still completes. The FSM then returns to IDLE with no ack and no err.
- No pipelining: new requests are ignored outside IDLE. Back-to-back requests are separated by at least the RESP-to-IDLE cycle.
- Reset:
  - All outputs go to 0 and the state goes to IDLE at the first edge sampling RSTn low.
  - A RAM write whose ACCESS cycle coincides with the reset edge still commits, because the RAM has no reset. A bench must accept either old or new data at that address.

## Timing
- Request sampled at edge k (IDLE). Response appears in:
  - Write ack: cycle k+2.
  - Read ack: cycle k+3.
  - Error: cycle k+1.
- ram_en is high only during cycle k+1. It is never high for two consecutive cycles.
- wb_ack_o and wb_err_o are mutually exclusive and each lasts exactly one cycle.
- All outputs are registered; there are no combinational paths from wb_* inputs to outputs.

## Structure
- Package ram_wb_pkg:
  - State enum (IDLE, ACCESS, CAPTURE, RESP).
  - WORDS_DEFAULT = 6144.
  - RAM_AW = 13.
- Sub-module ram_wb_addr_dec: purely combinational hit and word-index decode, parameterised by BASE_ADDR and WORDS.

## Test plan
- Reset: hold RSTn low 3 cycles → all outputs 0, state IDLE. Then write 32'hDEADBEEF to BASE+0x0, sel=4'hF → ack at k+2; ram_we=4'hF, ram_a=0 during k+1.
- Read back BASE+0x0 → ack at k+3, wb_dat_o=32'hDEADBEEF. Then write sel=4'b0010, data 32'h0000_5A00, and read → 32'hDEAD5AEF.
- Last-word boundary and miss:
  - BASE+0x5FFC (word 6143) write/read round-trips.
  - BASE+0x6000 (word 6144) → err at k+1, ram_en never high.
  - BASE+0x8000 → err.
- Bank crossing: write distinct values to words 1023 and 1024 → read back each unchanged, and ram_a is 13'd1023 and 13'd1024 respectively.
- Abort and reset mid-operation:
  - Drop wb_cyc_i during CAPTURE of a read → no ack, FSM in IDLE next cycle, next request serviced normally.
  - Assert RSTn low in a read ACCESS cycle → no ack ever, outputs 0.
